// File: rtl/pc_control.sv
// Program counter, condition flags and run/halt control for a 16-bit core.
// Resolves B/BR redirects against the registered flags and freezes everything after HLT.
module pc_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic [15:0] reg_data,
    input  logic [2:0]  flag_in,
    input  logic [2:0]  flag_en,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic [2:0]  flags,
    output logic        branch_taken,
    output logic        hlt
);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    state_t      state;
    logic [3:0]  opcode;
    logic [2:0]  ccc;
    logic [8:0]  imm9;
    logic [15:0] b_target;
    logic [15:0] next_pc;
    logic        cond;
    logic        z, v, n;

    assign opcode   = instr[15:12];
    assign ccc      = instr[11:9];
    assign imm9     = instr[8:0];
    assign z        = flags[2];
    assign v        = flags[1];
    assign n        = flags[0];
    assign pc_plus2 = pc + 16'd2;
    assign b_target = pc_plus2 + {{6{imm9[8]}}, imm9, 1'b0};

    always_comb begin
        cond = 1'b0;
        case (ccc)
            3'b000: cond = ~z;
            3'b001: cond = z;
            3'b010: cond = ~z & ~n;
            3'b011: cond = n;
            3'b100: cond = z | (~z & ~n);
            3'b101: cond = n | z;
            3'b110: cond = v;
            3'b111: cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    assign branch_taken = (state == RUN) && ((opcode == OP_B) || (opcode == OP_BR)) && cond;
    assign next_pc      = branch_taken ? ((opcode == OP_BR) ? reg_data : b_target) : pc_plus2;

    // Flags written here are only seen by the branch logic from the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            hlt   <= 1'b0;
            pc    <= 16'h0000;
            flags <= 3'b000;
        end else if (state == RUN) begin
            for (int i = 0; i < 3; i++)
                if (flag_en[i]) flags[i] <= flag_in[i];
            if (opcode == OP_HLT) begin
                state <= HALT;
                hlt   <= 1'b1;
            end else begin
                pc <= next_pc;
            end
        end
    end

endmodule

// File: tb/tb_pc_control.sv
// Randomized and directed checks of pc_control against an arithmetic reference model.
module tb_pc_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr, reg_data, pc, pc_plus2;
    logic [2:0]  flag_in, flag_en, flags;
    logic        branch_taken, hlt;

    int n_chk  = 0;
    int n_fail = 0;

    int m_pc;
    int m_flags;
    bit m_halted;

    always #5 clk = ~clk;

    pc_control dut (
        .clk(clk), .rst(rst), .instr(instr), .reg_data(reg_data),
        .flag_in(flag_in), .flag_en(flag_en), .pc(pc), .pc_plus2(pc_plus2),
        .flags(flags), .branch_taken(branch_taken), .hlt(hlt)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_cond(input int ccc, input int f);
        bit z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (ccc)
            0: return !z;
            1: return z;
            2: return !z && !n;
            3: return n;
            4: return z || (!z && !n);
            5: return n || z;
            6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit model_taken(input logic [15:0] ins);
        int op = ins[15:12];
        if (m_halted) return 1'b0;
        return (op == 12 || op == 13) && model_cond(ins[11:9], m_flags);
    endfunction

    // One instruction: check combinational outputs mid-cycle, clock it, check registered state.
    task automatic step(input logic [15:0] ins, input logic [15:0] rd,
                        input logic [2:0] fi, input logic [2:0] fe);
        bit tk;
        int off, op;
        instr = ins; reg_data = rd; flag_in = fi; flag_en = fe;
        #2;
        tk = model_taken(ins);
        chk("branch_taken", {15'd0, branch_taken}, {15'd0, tk});
        chk("pc_plus2", pc_plus2, 16'((m_pc + 2) % 65536));
        op = ins[15:12];
        if (!m_halted) begin
            if (op == 15) m_halted = 1'b1;
            else if (tk && op == 13) m_pc = rd;
            else if (tk) begin
                off  = (ins[8:0] >= 256) ? int'(ins[8:0]) - 512 : int'(ins[8:0]);
                m_pc = (m_pc + 2 + 2 * off + 65536) % 65536;
            end else m_pc = (m_pc + 2) % 65536;
            for (int i = 0; i < 3; i++)
                if (fe[i]) m_flags[i] = fi[i];
        end
        @(posedge clk);
        #1;
        chk("pc", pc, 16'(m_pc));
        chk("flags", {13'd0, flags}, 16'(m_flags));
        chk("hlt", {15'd0, hlt}, {15'd0, m_halted});
    endtask

    // Reset pulse placed between edges; outputs must clear before any edge arrives.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        m_pc = 0; m_flags = 0; m_halted = 1'b0;
        chk("rst_pc", pc, 16'h0000);
        chk("rst_hlt", {15'd0, hlt}, 16'd0);
        chk("rst_flags", {13'd0, flags}, 16'd0);
        chk("rst_taken", {15'd0, branch_taken}, {15'd0, model_taken(instr)});
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; instr = 16'h0000; reg_data = 16'h0000; flag_in = 3'b000; flag_en = 3'b000;
        m_pc = 0; m_flags = 0; m_halted = 1'b0;
        #2;
        chk("reset_pc", pc, 16'h0000);
        chk("reset_hlt", {15'd0, hlt}, 16'd0);
        instr = 16'hC000;
        #1;
        chk("reset_taken_ccc000", {15'd0, branch_taken}, 16'd1);
        instr = 16'hC400;
        #1;
        chk("reset_taken_ccc010", {15'd0, branch_taken}, 16'd1);
        instr = 16'h0000;
        @(posedge clk);
        #1;
        chk("reset_held_pc", pc, 16'h0000);
        rst = 1'b0;

        // Fetch wrap across 0xFFFF
        step(16'hDE00, 16'hFFFC, 3'b000, 3'b000);
        chk("wrap_preload", pc, 16'hFFFC);
        step(16'h0000, 16'h0, 3'b000, 3'b000); chk("wrap_fffe", pc, 16'hFFFE);
        step(16'h0000, 16'h0, 3'b000, 3'b000); chk("wrap_0000", pc, 16'h0000);
        step(16'h0000, 16'h0, 3'b000, 3'b000); chk("wrap_0002", pc, 16'h0002);

        // Backward B
        step(16'hDE00, 16'h0010, 3'b000, 3'b000);
        step(16'hCFFE, 16'h0, 3'b000, 3'b000); chk("b_back", pc, 16'h000E);

        // Conditional not taken with Z=1, then taken with Z=0
        step(16'h0000, 16'h0, 3'b100, 3'b100);
        step(16'hDE00, 16'h0020, 3'b000, 3'b000);
        step(16'hC004, 16'h0, 3'b000, 3'b000); chk("cond_nt", pc, 16'h0022);
        step(16'h0000, 16'h0, 3'b000, 3'b100);
        step(16'hDE00, 16'h0020, 3'b000, 3'b000);
        step(16'hC004, 16'h0, 3'b000, 3'b000); chk("cond_t", pc, 16'h002A);

        // Same-cycle flag write uses old flags
        step(16'hC204, 16'h0, 3'b100, 3'b100); chk("same_cyc_nt", pc, 16'h002C);
        step(16'hC204, 16'h0, 3'b000, 3'b000); chk("next_cyc_t", pc, 16'h0036);

        // Halt and freeze
        step(16'hDE00, 16'h0040, 3'b000, 3'b000);
        step(16'hF000, 16'h0, 3'b000, 3'b000);
        chk("hlt_pc", pc, 16'h0040);
        chk("hlt_set", {15'd0, hlt}, 16'd1);
        for (int i = 0; i < 10; i++)
            step(16'hCE00, 16'h1234, 3'($urandom), 3'b111);
        chk("hlt_frozen_pc", pc, 16'h0040);
        async_reset();
        step(16'h0000, 16'h0, 3'b000, 3'b000); chk("post_rst_pc", pc, 16'h0002);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if (m_halted && $urandom_range(0, 3) == 0) async_reset();
            else if ($urandom_range(0, 99) == 0) async_reset();
            else step(16'($urandom), 16'($urandom), 3'($urandom), 3'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
